ws2812_cmd_loader: RTL and testbench
====================================

Name: ws2812_cmd_loader

Overview:
- Upstream feeder for the ws2812 driver: parses a byte stream (from the UART receiver) into LED colour writes.
- Drives the driver's led_num / rgb_data / write inputs directly.
- 4-byte packets: [index, c0, c1, c2]. Index 0xFF is a broadcast fill that writes the same colour to every LED.
- Inter-byte timeout resynchronises the parser after a dropped byte.

Parameters:
- leds, 8, number of LEDs on the chain; must match the driver's leds; range 1..255.
- timeout, 100000, idle clock cycles inside a partial packet before the packet is discarded; >= 1.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-low reset
- rx_data  in  8  incoming byte
- rx_valid  in  1  rx_data valid this cycle
- rx_ready  out  1  loader can accept a byte; a byte transfers when rx_valid && rx_ready at a rising edge
- led_num  out  8  LED index to driver
- rgb_data  out  24  colour to driver; c0 in [23:16], c1 in [15:8], c2 in [7:0]
- write  out  1  one-cycle write strobe to driver
- done  out  1  one-cycle pulse: packet fully processed
- err_index  out  1  one-cycle pulse: packet index >= leds and != 0xFF; packet dropped

Behaviour:
- Reset (reset=0, async): state IDLE; led_num=0, rgb_data=0, write=0, done=0, err_index=0, timeout counter=0, fill counter=0.
- rx_ready is combinational: 1 in IDLE/IDX/C0/C1, 0 in FILL. It is therefore 1 during and directly after reset.
- Byte acceptance:
  - IDLE -> IDX: latch index.
  - IDX -> C0: latch c0.
  - C0 -> C1: latch c1.
  - On the c2 byte (accepted at edge N), the action happens during cycle N+1 and all outputs are registered:
    - index < leds: write=1, led_num=index, rgb_data={c0,c1,c2}, done=1; next state IDLE.
    - index == 0xFF: enter FILL. Cycle N+1 has write=1, led_num=0, rgb_data={c0,c1,c2}. Each following cycle increments led_num, with write=1 each cycle. The final write (led_num=leds-1) carries done=1. The cycle after it, write=0 and state is IDLE.
    - Any other index: write=0, done=1, err_index=1 in cycle N+1; next state IDLE.
- After the action, rgb_data and led_num hold their last values; write, done and err_index are 1 only for the cycles above.
- leds=1 fill: single write cycle, which also carries done=1.
- Timeout:
  - In IDX/C0/C1 the counter increments each cycle without an accepted byte and clears on every accepted byte.
  - When it reaches timeout-1 with no byte that cycle, the state returns to IDLE next edge and the counter clears. No write, done or err_index pulse.
  - A byte accepted in the same cycle the limit is reached wins: it is consumed normally and the counter clears.
  - The counter is held at 0 in IDLE and FILL.
- Bytes presented while rx_ready=0 are not consumed; the upstream holds them.
- Reset asserted mid-packet or mid-fill aborts immediately. Partial data is discarded and no further write occurs.
- Counter widths come from $clog2(timeout) and 8-bit indices. Index arithmetic never wraps because fill stops at leds-1.

Test Plan:
- Single write, leds=2: bytes 01,AA,BB,CC back-to-back -> exactly one write cycle with led_num=1, rgb_data=AABBCC, done=1 in that cycle; rx_ready stays 1 throughout.
- Fill, leds=4: bytes FF,12,34,56 -> write high 4 consecutive cycles, led_num 0,1,2,3, rgb_data=123456; done only on the led_num=3 cycle; rx_ready=0 for those 4 cycles. A 5th byte held during the fill is accepted on the first cycle rx_ready returns to 1.
- Bad index, leds=2: bytes 05,11,22,33 -> no write; one cycle with done=1, err_index=1. A following 00,01,02,03 writes led 0 = 010203.
- Timeout, timeout=16: byte 01, then 20 idle cycles, then 00,DE,AD,BE -> the 01 fragment is discarded and a single write occurs with led_num=0, rgb_data=DEADBE. Repeat with the gap at 15 cycles -> bytes parse as 01,00,DE,AD and write led 1 = 00DEAD.
- Reset mid-fill, leds=8: assert reset on the 3rd fill write -> write drops to 0 asynchronously and all outputs are 0. After release, rx_ready=1 and state is IDLE; the next 4-byte packet parses from its first byte.

Source files
------------

// File: rtl/ws2812_cmd_loader.sv
// ws2812_cmd_loader: parses 4-byte [index,c0,c1,c2] packets into ws2812 driver writes
module ws2812_cmd_loader #(
  parameter int leds = 8,
  parameter int timeout = 100000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic        rx_ready,
  output logic [7:0]  led_num,
  output logic [23:0] rgb_data,
  output logic        write,
  output logic        done,
  output logic        err_index
);
  localparam int tw = timeout > 1 ? $clog2(timeout) : 1;
  localparam logic [tw-1:0] cnt_max = tw'(timeout - 1);
  localparam logic [7:0] last_led = 8'(leds - 1);
  localparam logic [7:0] num_leds = 8'(leds);
  typedef enum logic [2:0] {IDLE, IDX, C0, C1, FILL} state_t;
  state_t state_q, state_d;
  logic [7:0] idx_q, idx_d, c0_q, c0_d, c1_q, c1_d, led_num_q, led_num_d;
  logic [23:0] rgb_q, rgb_d;
  logic [tw-1:0] cnt_q, cnt_d;
  logic write_q, write_d, done_q, done_d, err_q, err_d;
  logic acc;
  assign rx_ready = state_q != FILL;
  assign acc = rx_valid && rx_ready;
  assign led_num = led_num_q;
  assign rgb_data = rgb_q;
  assign write = write_q;
  assign done = done_q;
  assign err_index = err_q;
  // Parser, fill sequencer and inter-byte timeout; strobes default low every cycle
  always_comb begin
    state_d = state_q;
    idx_d = idx_q;
    c0_d = c0_q;
    c1_d = c1_q;
    led_num_d = led_num_q;
    rgb_d = rgb_q;
    cnt_d = '0;
    write_d = 1'b0;
    done_d = 1'b0;
    err_d = 1'b0;
    if (state_q == FILL) begin
      if (led_num_q == last_led) begin
        state_d = IDLE;
      end else begin
        led_num_d = led_num_q + 8'd1;
        write_d = 1'b1;
        done_d = led_num_q + 8'd1 == last_led;
      end
    end else if (acc) begin
      case (state_q)
        IDLE: begin
          idx_d = rx_data;
          state_d = IDX;
        end
        IDX: begin
          c0_d = rx_data;
          state_d = C0;
        end
        C0: begin
          c1_d = rx_data;
          state_d = C1;
        end
        default: begin
          state_d = IDLE;
          if (idx_q == 8'hFF) begin
            state_d = FILL;
            write_d = 1'b1;
            led_num_d = 8'd0;
            rgb_d = {c0_q, c1_q, rx_data};
            done_d = last_led == 8'd0;
          end else if (idx_q < num_leds) begin
            write_d = 1'b1;
            done_d = 1'b1;
            led_num_d = idx_q;
            rgb_d = {c0_q, c1_q, rx_data};
          end else begin
            done_d = 1'b1;
            err_d = 1'b1;
          end
        end
      endcase
    end else if (state_q != IDLE) begin
      cnt_d = cnt_q + 1'b1;
      if (cnt_q == cnt_max) begin
        cnt_d = '0;
        state_d = IDLE;
      end
    end
  end
  // State and registered driver outputs, cleared asynchronously
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      idx_q <= '0;
      c0_q <= '0;
      c1_q <= '0;
      led_num_q <= '0;
      rgb_q <= '0;
      cnt_q <= '0;
      write_q <= 1'b0;
      done_q <= 1'b0;
      err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q <= idx_d;
      c0_q <= c0_d;
      c1_q <= c1_d;
      led_num_q <= led_num_d;
      rgb_q <= rgb_d;
      cnt_q <= cnt_d;
      write_q <= write_d;
      done_q <= done_d;
      err_q <= err_d;
    end
  end
endmodule

// File: tb/tb_ws2812_cmd_loader.sv
// tb_ws2812_cmd_loader: scoreboard bench for the packet loader (leds=4, timeout=16)
module tb_ws2812_cmd_loader;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic [7:0] rx_data = 8'd0;
  logic rx_valid = 1'b0;
  logic rx_ready, write, done, err_index;
  logic [7:0] led_num;
  logic [23:0] rgb_data;
  logic [34:0] sb[$];
  logic [7:0] m_led = 8'd0;
  logic [23:0] m_rgb = 24'd0;
  int total = 0;
  int passed = 0;
  int stalls;

  ws2812_cmd_loader #(.leds(4), .timeout(16)) dut (
    .clk(clk), .reset(reset), .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .led_num(led_num), .rgb_data(rgb_data), .write(write), .done(done), .err_index(err_index)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic expect_out(input logic [7:0] l, input logic [23:0] c, input logic w, input logic d, input logic e);
    sb.push_back({w, d, e, l, c});
  endtask

  task automatic exp_write(input logic [7:0] l, input logic [23:0] c, input logic d);
    m_led = l;
    m_rgb = c;
    expect_out(l, c, 1'b1, d, 1'b0);
  endtask

  task automatic send(input logic [7:0] b);
    int n = 0;
    rx_data = b;
    rx_valid = 1'b1;
    @(negedge clk);
    while (!rx_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!rx_ready) chk("rx_ready_timeout", 64'(n), 64'd0);
    stalls += n;
    @(posedge clk);
    #1 rx_valid = 1'b0;
  endtask

  task automatic send_pkt(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c, input logic [7:0] d);
    send(a);
    send(b);
    send(c);
    send(d);
  endtask

  // Monitor: every cycle with a strobe must match the head of the scoreboard
  always @(negedge clk) begin
    if (reset && (write || done || err_index)) begin
      if (sb.size() == 0) chk("unexpected_output", {29'd0, write, done, err_index, led_num, rgb_data}, 64'd0);
      else chk("sb_output", {29'd0, write, done, err_index, led_num, rgb_data}, {29'd0, sb.pop_front()});
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    #2 reset = 1'b0;
    #1;
    chk("reset_outputs", {write, done, err_index, led_num, rgb_data}, 64'd0);
    chk("reset_rx_ready", 64'(rx_ready), 64'd1);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    stalls = 0;
    exp_write(8'd1, 24'hAABBCC, 1'b1);
    send_pkt(8'h01, 8'hAA, 8'hBB, 8'hCC);
    #2 chk("single_rx_ready_after", 64'(rx_ready), 64'd1);
    chk("single_no_stall", 64'(stalls), 64'd0);
    repeat (3) @(posedge clk);
    #1 exp_write(8'd3, 24'h010203, 1'b1);
    send_pkt(8'h03, 8'h01, 8'h02, 8'h03);
    exp_write(8'd0, 24'h123456, 1'b0);
    exp_write(8'd1, 24'h123456, 1'b0);
    exp_write(8'd2, 24'h123456, 1'b0);
    exp_write(8'd3, 24'h123456, 1'b1);
    send_pkt(8'hFF, 8'h12, 8'h34, 8'h56);
    stalls = 0;
    exp_write(8'd2, 24'hABCDEF, 1'b1);
    send(8'h02);
    chk("fill_ready_low_cycles", 64'(stalls), 64'd4);
    send(8'hAB);
    send(8'hCD);
    send(8'hEF);
    expect_out(m_led, m_rgb, 1'b0, 1'b1, 1'b1);
    send_pkt(8'h05, 8'h11, 8'h22, 8'h33);
    expect_out(m_led, m_rgb, 1'b0, 1'b1, 1'b1);
    send_pkt(8'h04, 8'h11, 8'h22, 8'h33);
    exp_write(8'd0, 24'h010203, 1'b1);
    send_pkt(8'h00, 8'h01, 8'h02, 8'h03);
    repeat (3) @(posedge clk);
    #1 send(8'h01);
    repeat (20) @(posedge clk);
    #1 exp_write(8'd0, 24'hDEADBE, 1'b1);
    send_pkt(8'h00, 8'hDE, 8'hAD, 8'hBE);
    repeat (3) @(posedge clk);
    #1 send(8'h01);
    repeat (15) @(posedge clk);
    #1 exp_write(8'd1, 24'h00DEAD, 1'b1);
    send(8'h00);
    send(8'hDE);
    send(8'hAD);
    repeat (3) @(posedge clk);
    #1 chk("timeout_pending", 64'(sb.size()), 64'd0);
    exp_write(8'd0, 24'h0A0B0C, 1'b0);
    exp_write(8'd1, 24'h0A0B0C, 1'b0);
    exp_write(8'd2, 24'h0A0B0C, 1'b0);
    send_pkt(8'hFF, 8'h0A, 8'h0B, 8'h0C);
    begin
      int n = 0;
      while (!(write && led_num == 8'd2) && n < 20) begin
        @(posedge clk);
        #1 n++;
      end
      chk("fill_reaches_led2", 64'(write && led_num == 8'd2), 64'd1);
    end
    @(negedge clk);
    #1 reset = 1'b0;
    #1;
    chk("midfill_reset_outputs", {write, done, err_index, led_num, rgb_data}, 64'd0);
    chk("midfill_reset_rx_ready", 64'(rx_ready), 64'd1);
    #7 reset = 1'b1;
    m_led = 8'd0;
    m_rgb = 24'd0;
    @(posedge clk);
    #1 chk("post_reset_rx_ready", 64'(rx_ready), 64'd1);
    exp_write(8'd1, 24'h112233, 1'b1);
    send_pkt(8'h01, 8'h11, 8'h22, 8'h33);
    repeat (5) @(posedge clk);
    #1 chk("sb_drained", 64'(sb.size()), 64'd0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
